mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - Sequences every data-memory access of the multi-cycle CPU (lb/lbu/lh/lhu/lw, sb/sh/sw) over a req/ready handshake.
// - Owns address alignment checks, byte-enable and store-lane generation, and load lane select with sign/zero extension.
// - Sits between the MEM-stage control FSM and the data memory; the control FSM holds in MEM until done or fault pulses.
// PARAMETERS
// - TIMEOUT  16  max cycles in WAIT before a bus fault; 0 disables the timeout
// PORTS
// - clk        in   1   system clock; all state updates on the rising edge
// - rst        in   1   synchronous, active-high reset
// - start      in   1   access request from control FSM; sampled only in IDLE
// - is_store   in   1   1 = store, 0 = load; sampled with start
// - ls_option  in   3   000 byte signed, 001 byte unsigned, 010 half signed, 011 half unsigned, 100 word; stores use 000/010/100
// - addr       in   32  byte address; sampled with start
// - wdata      in   32  store data, right-justified; sampled with start
// - mem_req    out  1   request to data memory
// - mem_we     out  1   write strobe, valid with mem_req
// - mem_be     out  4   byte enables, valid with mem_req
// - mem_addr   out  32  word-aligned address {addr[31:2],2'b00}
// - mem_wdata  out  32  store data replicated to the addressed lane(s)
// - mem_rdata  in   32  memory read word; valid when mem_ready=1
// - mem_ready  in   1   memory completion; ignored unless mem_req=1
// - busy       out  1   1 in any state other than IDLE
// - done       out  1   1-cycle completion pulse
// - rdata      out  32  extended load result; holds value until the next load completes
// - fault      out  1   1-cycle pulse: misalignment, illegal option, or timeout
// - fault_code out  2   01 misaligned, 10 illegal option, 11 timeout; held until next start
// BEHAVIOUR
// - Reset: state IDLE; mem_req, mem_we, busy, done, fault = 0; mem_be = 4'b0000; mem_addr, mem_wdata, rdata = 0; fault_code = 00.
// - Reset during any state aborts the access immediately; mem_req drops the next cycle with no completion.
// - IDLE: on start, capture is_store/ls_option/addr/wdata. Illegal option (101-111, or 001/011 with a store) -> FAULT.
//   Misalignment (half with addr[0]=1, word with addr[1:0]!=00) -> FAULT. Otherwise -> REQ.
// - REQ (1 cycle): assert mem_req, mem_we and mem_be; -> WAIT. Outputs are registered and stay stable through WAIT.
// - WAIT: hold request until mem_ready=1. Load: latch extended rdata from mem_rdata; -> DONE.
//   Store: -> DONE. If the wait counter reaches TIMEOUT (TIMEOUT>0) -> FAULT with code 11.
// - mem_ready in the same cycle as the counter reaching TIMEOUT: completion wins.
// - DONE: done=1, mem_req=0; -> IDLE. Access latency with 0-wait memory: start at T, REQ at T+1, ready at T+1, done at T+2.
// - FAULT: fault=1 for 1 cycle, mem_req never asserted for option or alignment faults; -> IDLE.
// - start in any non-IDLE state is ignored; the controller does not queue requests.
// - mem_be: byte -> 0001 << addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
// - mem_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
// - Load extension: select byte lane addr[1:0] or half lane addr[1]; signed options replicate the lane MSB
//   into the upper bits, unsigned options fill with zero; word passes through unchanged.
// STRUCTURE
// - Shared package: ls_option encodings (LS_B, LS_BU, LS_H, LS_HU, LS_W), fault code constants, FSM state encoding
//   (IDLE, REQ, WAIT, DONE, FAULT).
// - One sub-module: load_lane_ext, combinational (mem_rdata, addr[1:0], ls_option) -> 32-bit extended value.
// - Store lane and byte-enable logic plus the wait counter stay in this module.
// TESTING
// - lb at addr 0x103, mem_rdata 0x80FF_1234 with 0 wait states -> mem_be 1000, rdata 0xFFFF_FF80, done at T+2.
// - lhu at addr 0x102, rdata 0x8001_0000 with 3 wait states -> mem_addr 0x100, rdata 0x0000_8001, busy for 5 cycles.
// - sb addr 0x21, wdata 0x0000_00AB -> mem_we=1, mem_be 0010, mem_wdata 0xABAB_ABAB, done pulse.
// - lw addr 0x102 -> fault=1, fault_code 01, mem_req never asserted. sh with option 011 -> fault_code 10.
// - TIMEOUT=16 with mem_ready held 0 -> fault with code 11 after 16 WAIT cycles; mem_req drops and state returns to IDLE.
// - rst asserted in WAIT -> next cycle all outputs at reset values; a fresh start after rst completes normally.
// - Back-to-back: start re-asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared encodings and lane helpers for the data-memory access controller
package mem_access_ctrl_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_BU = 3'b001;
  localparam logic [2:0] LS_H  = 3'b010;
  localparam logic [2:0] LS_HU = 3'b011;
  localparam logic [2:0] LS_W  = 3'b100;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;

  // Unsigned variants only make sense for loads; stores must use B/H/W.
  function automatic logic opt_illegal(input logic [2:0] opt, input logic store);
    return (opt > LS_W) || (store && (opt == LS_BU || opt == LS_HU));
  endfunction

  function automatic logic misaligned(input logic [2:0] opt, input logic [1:0] lo);
    case (opt)
      LS_H, LS_HU: return lo[0];
      LS_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] opt, input logic [1:0] lo);
    case (opt)
      LS_W:        return 4'b1111;
      LS_H, LS_HU: return lo[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b0001 << lo;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] opt, input logic [31:0] wd);
    case (opt)
      LS_W:        return wd;
      LS_H, LS_HU: return {2{wd[15:0]}};
      default:     return {4{wd[7:0]}};
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-memory request/ready bus between controller and memory
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_ctrl_load_lane_ext.sv
// rtl/mem_access_ctrl_load_lane_ext.sv - selects the addressed load lane and sign/zero extends it
module load_lane_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ls_option,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_rdata[7:0];
    case (addr_lo)
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      2'd3:    byte_v = mem_rdata[31:24];
      default: byte_v = mem_rdata[7:0];
    endcase
    half_v = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (ls_option)
      LS_B:    ext_data = {{24{byte_v[7]}}, byte_v};
      LS_BU:   ext_data = {24'd0, byte_v};
      LS_H:    ext_data = {{16{half_v[15]}}, half_v};
      LS_HU:   ext_data = {16'd0, half_v};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences one CPU load/store over the data-memory req/ready bus
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_store,
  input  logic [2:0]         ls_option,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  mem_access_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [31:0]        rdata,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic          is_store_q;
  logic [2:0]    opt_q;
  logic [1:0]    addr_lo_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   ext_data;
  logic          timeout_hit;

  load_lane_ext u_ext (
    .mem_rdata (bus.mem_rdata),
    .addr_lo   (addr_lo_q),
    .ls_option (opt_q),
    .ext_data  (ext_data)
  );

  // Every request cycle without ready counts, including the first (REQ) one.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      is_store_q    <= 1'b0;
      opt_q         <= LS_B;
      addr_lo_q     <= 2'b00;
      wait_cnt      <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= FC_NONE;
      rdata         <= 32'd0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            opt_q      <= ls_option;
            addr_lo_q  <= addr[1:0];
            wait_cnt   <= '0;
            busy       <= 1'b1;
            if (opt_illegal(ls_option, is_store)) begin
              fault      <= 1'b1;
              fault_code <= FC_ILLEGAL;
              state      <= FAULT;
            end else if (misaligned(ls_option, addr[1:0])) begin
              fault      <= 1'b1;
              fault_code <= FC_MISALIGN;
              state      <= FAULT;
            end else begin
              fault_code    <= FC_NONE;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= is_store;
              bus.mem_be    <= byte_en(ls_option, addr[1:0]);
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_wdata <= lane_wdata(ls_option, wdata);
              state         <= REQ;
            end
          end
        end
        // REQ also accepts ready so a zero-wait memory finishes in two cycles.
        REQ, WAIT: begin
          if (bus.mem_ready) begin
            if (!is_store_q) rdata <= ext_data;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else if (timeout_hit) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            fault       <= 1'b1;
            fault_code  <= FC_TIMEOUT;
            state       <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            state    <= WAIT;
          end
        end
        DONE, FAULT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  ls_option;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_code;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .ls_option  (ls_option),
    .addr       (addr),
    .wdata      (wdata),
    .bus        (bus_if),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_busy, exp_done, exp_fault, exp_req, exp_we;
  logic [1:0]  exp_code;
  logic [3:0]  exp_be;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;

  int          obs_busy, obs_done_k, obs_fault_k, obs_req_cnt;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  function automatic logic [31:0] m_ext(input logic [31:0] rd, input logic [1:0] a, input logic [2:0] o);
    logic [31:0] v;
    if (o == 3'd0 || o == 3'd1) begin
      v = (rd >> (8 * int'(a))) & 32'hFF;
      if (o == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (o == 3'd2 || o == 3'd3) begin
      v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      if (o == 3'd2 && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] a, input logic [2:0] o);
    logic [7:0] v;
    if (o == 3'd4)      v = 8'd15;
    else if (o >= 3'd2) v = 8'd3 << (a & 2'd2);
    else                v = 8'd1 << a;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] wd, input logic [2:0] o);
    if (o == 3'd4) return wd;
    if (o >= 3'd2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return {24'd0, wd[7:0]} * 32'h0101_0101;
  endfunction

  task automatic set_reset_exp();
    exp_busy = 0; exp_done = 0; exp_fault = 0; exp_req = 0; exp_we = 0;
    exp_code = 2'b00; exp_rdata = 32'd0; exp_be = 4'd0; exp_addr = 32'd0; exp_wdata = 32'd0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("fault", {31'd0, fault}, {31'd0, exp_fault});
      chk("fault_code", {30'd0, fault_code}, {30'd0, exp_code});
      chk("rdata", rdata, exp_rdata);
      chk("mem_req", {31'd0, bus_if.mem_req}, {31'd0, exp_req});
      if (exp_req) begin
        chk("mem_we", {31'd0, bus_if.mem_we}, {31'd0, exp_we});
        chk("mem_be", {28'd0, bus_if.mem_be}, {28'd0, exp_be});
        chk("mem_addr", bus_if.mem_addr, exp_addr);
        chk("mem_wdata", bus_if.mem_wdata, exp_wdata);
      end
    end
  end

  // Called just after a rising edge in an idle cycle; returns just after the edge of the
  // next idle cycle, so a following call issues start back-to-back.
  // noise: 0 quiet, 1 random start pulses while busy, 2 start held high while busy.
  task automatic run_txn(input logic st, input logic [2:0] opt, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int w,
                         input int noise, input int rst_at);
    logic ill, mis, flt, tmo;
    int   last;
    ill  = (opt > 3'd4) || (st && (opt == 3'd1 || opt == 3'd3));
    mis  = !ill && (((opt == 3'd2 || opt == 3'd3) && a[0]) || (opt == 3'd4 && a[1:0] != 2'b00));
    flt  = ill || mis;
    tmo  = !flt && (w >= TMO);
    last = flt ? 2 : (tmo ? TMO + 2 : w + 3);
    if (rst_at > 0) last = rst_at + 1;
    obs_busy = 0; obs_done_k = 0; obs_fault_k = 0; obs_req_cnt = 0;
    start = 1; is_store = st; ls_option = opt; addr = a; wdata = wd;
    bus_if.mem_ready = 1'($urandom); bus_if.mem_rdata = $urandom;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      obs_busy    += int'(busy);
      obs_req_cnt += int'(bus_if.mem_req);
      if (done)  obs_done_k  = k;
      if (fault) obs_fault_k = k;
      if (k == 1) begin
        obs_be = bus_if.mem_be; obs_addr = bus_if.mem_addr;
        obs_wdata = bus_if.mem_wdata; obs_we = bus_if.mem_we;
      end
      if (rst_at > 0 && k == rst_at + 1) begin
        set_reset_exp();
        rst = 0; start = 0;
        continue;
      end
      exp_done = 0; exp_fault = 0; exp_req = 0;
      exp_busy = (k < last);
      if (k == 1) exp_code = ill ? 2'b10 : (mis ? 2'b01 : 2'b00);
      if (flt) begin
        exp_fault = (k == 1);
      end else if (tmo) begin
        exp_req = (k <= TMO);
        if (k == TMO + 1) begin exp_fault = 1; exp_code = 2'b11; end
      end else begin
        exp_req = (k <= w + 1);
        if (k == w + 2) begin
          exp_done = 1;
          if (!st) exp_rdata = m_ext(rd, a[1:0], opt);
        end
      end
      if (exp_req) begin
        exp_we = st; exp_be = m_be(a[1:0], opt);
        exp_addr = a & 32'hFFFF_FFFC; exp_wdata = m_wd(wd, opt);
      end
      start = 0;
      if (k < last && rst_at == 0) begin
        if (noise == 2) start = 1;
        else if (noise == 1) start = 1'($urandom);
        if (start) begin
          is_store = 1'($urandom); ls_option = 3'($urandom); addr = $urandom; wdata = $urandom;
        end
      end
      bus_if.mem_ready = exp_req ? (k == w + 1) : 1'($urandom);
      bus_if.mem_rdata = (exp_req && k == w + 1) ? rd : $urandom;
      if (rst_at > 0 && k == rst_at) rst = 1;
    end
  endtask

  initial begin
    logic        st;
    logic [2:0]  opt;
    logic [31:0] a;
    int          pick, w;

    rst = 1; start = 0; is_store = 0; ls_option = 3'd0; addr = 0; wdata = 0;
    bus_if.mem_ready = 0; bus_if.mem_rdata = 0;
    set_reset_exp();
    repeat (2) @(posedge clk);
    #1; chk_en = 1;
    @(posedge clk); #1;
    rst = 0;

    // lb, zero wait states
    run_txn(0, 3'd0, 32'h103, 32'd0, 32'h80FF_1234, 0, 0, 0);
    chk("lb_be", {28'd0, obs_be}, 32'h8);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_done_at", obs_done_k, 2);

    // lhu, three wait states
    run_txn(0, 3'd3, 32'h102, 32'd0, 32'h8001_0000, 3, 1, 0);
    chk("lhu_addr", obs_addr, 32'h100);
    chk("lhu_rdata", rdata, 32'h0000_8001);
    chk("lhu_busy_cycles", obs_busy, 5);

    // sb
    run_txn(1, 3'd0, 32'h21, 32'h0000_00AB, 32'd0, 0, 0, 0);
    chk("sb_we", {31'd0, obs_we}, 32'd1);
    chk("sb_be", {28'd0, obs_be}, 32'h2);
    chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    chk("sb_done_at", obs_done_k, 2);
    chk("sb_rdata_held", rdata, 32'h0000_8001);

    // alignment and option faults
    run_txn(0, 3'd4, 32'h102, 32'd0, 32'd0, 0, 0, 0);
    chk("lw_mis_fault_at", obs_fault_k, 1);
    chk("lw_mis_code", {30'd0, fault_code}, 32'd1);
    chk("lw_mis_req", obs_req_cnt, 0);
    run_txn(1, 3'd3, 32'h100, 32'd0, 32'd0, 0, 0, 0);
    chk("sh_opt_code", {30'd0, fault_code}, 32'd2);
    chk("sh_opt_req", obs_req_cnt, 0);

    // timeout, and completion on the last allowed cycle
    run_txn(0, 3'd4, 32'h300, 32'd0, 32'd0, 99, 1, 0);
    chk("tmo_fault_at", obs_fault_k, TMO + 1);
    chk("tmo_req_cycles", obs_req_cnt, TMO);
    chk("tmo_code", {30'd0, fault_code}, 32'd3);
    run_txn(0, 3'd4, 32'h304, 32'd0, 32'h5A5A_0F0F, TMO - 1, 0, 0);
    chk("edge_done_at", obs_done_k, TMO + 1);
    chk("edge_rdata", rdata, 32'h5A5A_0F0F);

    // reset in WAIT, then a fresh access
    run_txn(0, 3'd4, 32'h200, 32'd0, 32'hDEAD_BEEF, 99, 0, 5);
    run_txn(0, 3'd4, 32'h204, 32'd0, 32'h1234_5678, 1, 0, 0);
    chk("post_rst_rdata", rdata, 32'h1234_5678);

    // back-to-back with start held through DONE
    run_txn(0, 3'd2, 32'h42, 32'd0, 32'h0000_9ABC, 0, 2, 0);
    chk("b2b_first_busy", obs_busy, 2);
    run_txn(0, 3'd1, 32'h41, 32'd0, 32'h0000_C300, 0, 0, 0);
    chk("b2b_second_rdata", rdata, 32'h0000_00C3);

    for (int i = 0; i < 150; i++) begin
      st  = 1'($urandom);
      opt = 3'($urandom);
      if ($urandom_range(0, 3) != 0) opt = 3'($urandom_range(0, 4));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (opt == 3'd4) a[1:0] = 2'b00;
        else if (opt >= 3'd2) a[0] = 1'b0;
      end
      pick = $urandom_range(0, 9);
      w = (pick < 7) ? pick % 4 : (pick == 7 ? TMO - 1 : (pick == 8 ? TMO : TMO + 4));
      run_txn(st, opt, a, $urandom, $urandom, w, int'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
